// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: packs bytes into big-endian words, appends 0x80,
// zero fill and the 64-bit bit length, one 512-bit block at a time.
module sha256_msg_padder #(
    parameter int CNT_W = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load_enable,
    input  logic        input_complete,
    input  logic [7:0]  input_data,
    output logic        byte_ready,
    output logic [31:0] word_out,
    output logic        word_valid,
    input  logic        word_ready,
    output logic [3:0]  word_index,
    output logic        block_last,
    output logic        msg_done,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE, LOAD, PAD, ZERO, LEN_HI, LEN_LO, DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        asm_q, asm_d;
    logic [1:0]         apos_q, apos_d;
    logic               afull_q, afull_d;
    logic               armed_q, armed_d;
    logic [31:0]        out_q, out_d;
    logic               oval_q, oval_d;
    logic [3:0]         oidx_q, oidx_d;
    logic               olast_q, olast_d;
    logic [3:0]         widx_q, widx_d;

    logic        out_free;
    logic        in_phase;
    logic        cpl_acc;
    logic        byte_acc;
    logic [63:0] bit_len;
    logic [31:0] pad_word;
    logic [31:0] asm_new;
    logic        ld;
    logic [31:0] ld_word;
    logic        ld_last;

    assign out_free   = !oval_q || word_ready;
    assign in_phase   = (state_q == LOAD) || (state_q == IDLE && armed_q);
    assign byte_ready = in_phase && (!afull_q || out_free);
    assign cpl_acc    = input_complete && byte_ready;
    assign byte_acc   = load_enable && byte_ready && !input_complete;
    assign bit_len    = 64'({cnt_q, 3'b000});
    assign pad_word   = asm_q | (32'h8000_0000 >> {apos_q, 3'b000});

    // A drained full assembler is reused as empty by the byte arriving now.
    assign asm_new = (afull_q ? 32'h0 : asm_q)
                   | ({24'h0, input_data} << {~apos_q, 3'b000});

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        asm_d   = asm_q;
        apos_d  = apos_q;
        afull_d = afull_q;
        armed_d = armed_q;
        out_d   = out_q;
        oval_d  = oval_q;
        oidx_d  = oidx_q;
        olast_d = olast_q;
        widx_d  = widx_q;
        ld      = 1'b0;
        ld_word = 32'h0;
        ld_last = 1'b0;

        if (oval_q && word_ready) begin
            oval_d = 1'b0;
        end

        unique case (state_q)
            IDLE, LOAD: begin
                if (state_q == IDLE && !input_complete) begin
                    armed_d = 1'b1;
                end
                if (afull_q && out_free) begin
                    ld      = 1'b1;
                    ld_word = asm_q;
                    afull_d = 1'b0;
                    asm_d   = 32'h0;
                end
                if (cpl_acc) begin
                    state_d = PAD;
                end else if (byte_acc) begin
                    state_d = LOAD;
                    cnt_d   = cnt_q + 1'b1;
                    asm_d   = asm_new;
                    apos_d  = apos_q + 2'd1;
                    if (apos_q == 2'd3) begin
                        if (out_free) begin
                            ld      = 1'b1;
                            ld_word = asm_new;
                            asm_d   = 32'h0;
                        end else begin
                            afull_d = 1'b1;
                        end
                    end
                end
            end
            PAD: begin
                if (out_free) begin
                    ld      = 1'b1;
                    ld_word = pad_word;
                    asm_d   = 32'h0;
                    apos_d  = 2'd0;
                    state_d = (widx_q == 4'd13) ? LEN_HI : ZERO;
                end
            end
            ZERO: begin
                if (out_free) begin
                    ld = 1'b1;
                    if (widx_q == 4'd13) begin
                        state_d = LEN_HI;
                    end
                end
            end
            LEN_HI: begin
                if (out_free) begin
                    ld      = 1'b1;
                    ld_word = bit_len[63:32];
                    state_d = LEN_LO;
                end
            end
            LEN_LO: begin
                if (oval_q && olast_q) begin
                    if (word_ready) begin
                        state_d = DONE;
                    end
                end else if (out_free) begin
                    ld      = 1'b1;
                    ld_word = bit_len[31:0];
                    ld_last = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                armed_d = 1'b0;
                cnt_d   = '0;
                widx_d  = 4'd0;
                asm_d   = 32'h0;
                apos_d  = 2'd0;
                afull_d = 1'b0;
                olast_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        if (ld) begin
            out_d   = ld_word;
            oval_d  = 1'b1;
            oidx_d  = widx_q;
            olast_d = ld_last;
            widx_d  = widx_q + 4'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            asm_q   <= 32'h0;
            apos_q  <= 2'd0;
            afull_q <= 1'b0;
            armed_q <= 1'b1;
            out_q   <= 32'h0;
            oval_q  <= 1'b0;
            oidx_q  <= 4'd0;
            olast_q <= 1'b0;
            widx_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
            apos_q  <= apos_d;
            afull_q <= afull_d;
            armed_q <= armed_d;
            out_q   <= out_d;
            oval_q  <= oval_d;
            oidx_q  <= oidx_d;
            olast_q <= olast_d;
            widx_q  <= widx_d;
        end
    end

    assign word_out   = out_q;
    assign word_valid = oval_q;
    assign word_index = oidx_q;
    assign block_last = olast_q;
    assign msg_done   = (state_q == DONE);
    assign busy       = (state_q != IDLE) && (state_q != DONE);

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Scoreboard bench for sha256_msg_padder: a byte-level padding model feeds
// an expected-word queue that a handshake monitor drains and compares.
module tb_sha256_msg_padder;

    logic        clock = 1'b0;
    logic        reset;
    logic        load_enable;
    logic        input_complete;
    logic [7:0]  input_data;
    logic        byte_ready;
    logic [31:0] word_out;
    logic        word_valid;
    logic        word_ready;
    logic [3:0]  word_index;
    logic        block_last;
    logic        msg_done;
    logic        busy;

    sha256_msg_padder #(.CNT_W(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .load_enable    (load_enable),
        .input_complete (input_complete),
        .input_data     (input_data),
        .byte_ready     (byte_ready),
        .word_out       (word_out),
        .word_valid     (word_valid),
        .word_ready     (word_ready),
        .word_index     (word_index),
        .block_last     (block_last),
        .msg_done       (msg_done),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] w;
        logic [3:0]  idx;
        logic        last;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  msg_q[$];
    logic [31:0] got[16];
    int          checks = 0;
    int          errors = 0;
    int          ready_mode = 0;
    int          done_cnt = 0;
    bit          expect_done = 0;
    bit          prev_stall = 0;
    logic [36:0] prev_out;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Pad the message as a byte string, then slice it into 32-bit words.
    task automatic push_expected();
        logic [7:0]  p[$];
        logic [63:0] bl;
        int          nw;
        exp_t        e;
        p = msg_q;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        bl = 64'(msg_q.size()) * 64'd8;
        for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
        nw = p.size() / 4;
        for (int w = 0; w < nw; w++) begin
            e.w    = {p[4*w], p[4*w+1], p[4*w+2], p[4*w+3]};
            e.idx  = 4'(w % 16);
            e.last = (w == nw - 1);
            sb.push_back(e);
        end
    endtask

    initial begin
        word_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            case (ready_mode)
                0: word_ready = 1'b1;
                1: word_ready = ~word_ready;
                2: word_ready = 1'($urandom_range(0, 1));
                default: word_ready = 1'b0;
            endcase
        end
    end

    always @(negedge clock) begin
        exp_t e;
        if (reset) begin
            prev_stall  = 0;
            expect_done = 0;
        end else begin
            if (msg_done || expect_done) check("msg_done", 64'(msg_done), 64'(expect_done));
            if (msg_done) done_cnt++;
            expect_done = 0;
            if (prev_stall) begin
                check("stall_valid", 64'(word_valid), 64'd1);
                check("stall_hold", 64'({word_index, block_last, word_out}), 64'(prev_out));
            end
            if (word_valid && word_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %0h expected none", word_out);
                end else begin
                    e = sb.pop_front();
                    check("word", 64'(word_out), 64'(e.w));
                    check("index", 64'(word_index), 64'(e.idx));
                    check("last", 64'(block_last), 64'(e.last));
                    got[word_index] = word_out;
                    if (e.last) expect_done = 1;
                end
            end
            prev_stall = word_valid && !word_ready;
            prev_out   = {word_index, block_last, word_out};
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int t = 0;
        if (gaps && $urandom_range(0, 3) == 0) begin
            load_enable = 1'b0;
            input_data  = 8'($urandom);
            tick();
        end
        load_enable = 1'b1;
        input_data  = b;
        forever begin
            @(negedge clock);
            if (byte_ready) break;
            t++;
            if (t > 500) begin
                check("byte_timeout", 64'd0, 64'd1);
                break;
            end
        end
        tick();
        load_enable = 1'b0;
    endtask

    task automatic complete_msg(input bit keep_le);
        int t = 0;
        int d0 = done_cnt;
        input_complete = 1'b1;
        load_enable    = keep_le;
        forever begin
            @(negedge clock);
            if (byte_ready) break;
            t++;
            if (t > 500) begin
                check("cpl_timeout", 64'd0, 64'd1);
                break;
            end
        end
        tick();
        t = 0;
        while (done_cnt == d0 && t < 3000) begin
            tick();
            t++;
        end
        check("done_seen", 64'(done_cnt - d0), 64'd1);
        tick();
        check("busy_idle", 64'(busy), 64'd0);
        input_complete = 1'b0;
        load_enable    = 1'b0;
        tick();
        tick();
        check("queue_empty", 64'(sb.size()), 64'd0);
    endtask

    task automatic run_msg(input bit keep_le, input bit gaps);
        push_expected();
        foreach (msg_q[i]) send_byte(msg_q[i], gaps);
        complete_msg(keep_le);
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        sb.delete();
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        reset          = 1'b1;
        load_enable    = 1'b0;
        input_complete = 1'b0;
        input_data     = 8'h00;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("rst_byte_ready", 64'(byte_ready), 64'd1);
        check("rst_word_valid", 64'(word_valid), 64'd0);
        check("rst_word_out", 64'(word_out), 64'd0);
        check("rst_word_index", 64'(word_index), 64'd0);
        check("rst_block_last", 64'(block_last), 64'd0);
        check("rst_msg_done", 64'(msg_done), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);

        msg_q = '{8'h43, 8'h53, 8'h45, 8'h33, 8'h30, 8'h33, 8'h34, 8'h32};
        run_msg(1'b1, 1'b0);
        check("cse_w0", 64'(got[0]), 64'h43534533);
        check("cse_w1", 64'(got[1]), 64'h30333432);
        check("cse_w2", 64'(got[2]), 64'h80000000);
        check("cse_w3", 64'(got[3]), 64'h0);
        check("cse_w15", 64'(got[15]), 64'h40);

        reset_pulse();
        msg_q.delete();
        run_msg(1'b0, 1'b0);
        check("empty_w0", 64'(got[0]), 64'h80000000);
        check("empty_w15", 64'(got[15]), 64'h0);

        msg_q.delete();
        repeat (55) msg_q.push_back(8'h61);
        run_msg(1'b0, 1'b0);
        check("b55_w13", 64'(got[13]), 64'h61616180);
        check("b55_w14", 64'(got[14]), 64'h0);
        check("b55_w15", 64'(got[15]), 64'h1B8);

        msg_q.push_back(8'h61);
        run_msg(1'b0, 1'b0);
        check("b56_w13", 64'(got[13]), 64'h0);
        check("b56_w15", 64'(got[15]), 64'h1C0);

        msg_q.delete();
        repeat (64) msg_q.push_back(8'($urandom));
        push_expected();
        ready_mode = 3;
        for (int i = 0; i < 8; i++) send_byte(msg_q[i], 1'b0);
        tick();
        tick();
        @(negedge clock);
        check("full_byte_ready", 64'(byte_ready), 64'd0);
        check("full_word_valid", 64'(word_valid), 64'd1);
        check("full_busy", 64'(busy), 64'd1);
        tick();
        ready_mode = 1;
        for (int i = 8; i < 64; i++) send_byte(msg_q[i], 1'b0);
        complete_msg(1'b0);
        ready_mode = 0;
        check("b64_w0", 64'(got[0]), 64'h80000000);
        check("b64_w15", 64'(got[15]), 64'h200);

        msg_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        push_expected();
        foreach (msg_q[i]) send_byte(msg_q[i], 1'b0);
        reset = 1'b1;
        sb.delete();
        tick();
        tick();
        check("abort_valid", 64'(word_valid), 64'd0);
        check("abort_index", 64'(word_index), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        reset = 1'b0;
        tick();
        check("abort_ready", 64'(byte_ready), 64'd1);
        msg_q = '{8'h61, 8'h62, 8'h63};
        run_msg(1'b0, 1'b0);
        check("abc_w0", 64'(got[0]), 64'h61626380);
        check("abc_w15", 64'(got[15]), 64'h18);

        for (int m = 0; m < 10; m++) begin
            int len;
            len = $urandom_range(0, 130);
            msg_q.delete();
            for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
            ready_mode = $urandom_range(0, 2);
            run_msg(1'($urandom_range(0, 1)), 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sha256_msg_padder.md
Name: sha256_msg_padder

Overview:
- Upstream stage of the SHA-256 compression core. Takes the byte stream from the top-level load interface and emits padded 32-bit message words W0..W15 per 512-bit block.
- Padding per FIPS 180-4: 0x80, then zeros, then a 64-bit big-endian bit length. Multi-block messages are handled.
- Output uses a valid/ready handshake so the compression core can stall the padder. The padder then stalls input through byte_ready.

Parameters:
- CNT_W, 32: width of the internal byte counter. The length field is {zeros, byte_cnt, 3'b000}, zero-extended to 64 bits.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- load_enable  in  1  input_data is a valid byte this cycle.
- input_complete  in  1  level signal: message has ended; start padding.
- input_data  in  8  message byte.
- byte_ready  out  1  padder can accept a byte or a completion this cycle.
- word_out  out  32  message word, big-endian packed: first byte in [31:24].
- word_valid  out  1  word_out is valid.
- word_ready  in  1  consumer accepts word_out when word_valid && word_ready.
- word_index  out  4  index of word_out within its block, 0..15.
- block_last  out  1  word_out is W15 of the final block of the message.
- msg_done  out  1  one-cycle pulse in the cycle after the final word handshake.
- busy  out  1  high from the first accepted byte/completion until msg_done.

Behaviour:
- Reset values: byte_ready=1, word_valid=0, word_out=0, word_index=0, block_last=0, msg_done=0, busy=0. Byte counter, word assembler and FSM are cleared.
- Reset asserted mid-message discards all state, including a pending output word. The first cycle after reset deassertion is IDLE.
- Byte accept: load_enable && byte_ready && !input_complete. Bytes fill the assembler MSB-first and byte_cnt increments.
- input_complete has priority: when it is high, load_enable and input_data are ignored that cycle.
- Completion accept: input_complete && byte_ready in IDLE or LOAD. Transition to PAD.
- After msg_done the padder stays in IDLE, ignoring input_complete, until input_complete is sampled low (re-arm). It then accepts a new message.
- Word output: a full assembler word moves into the output register. word_valid rises the cycle after the 4th byte is accepted (latency 1).
- A single output register plus a single assembler are used:
  - byte_ready=0 while the assembler is full and the output register still holds an unaccepted word.
  - With word_ready held high, sustained input is 1 byte/cycle with no bubbles.
- word_out, word_index and block_last are held stable while word_valid && !word_ready.
- word_index increments on each handshake and wraps 15 -> 0.
- FSM states: IDLE, LOAD, PAD, ZERO, LEN_HI, LEN_LO, DONE.
  - IDLE -> LOAD on the first byte accept.
  - IDLE/LOAD -> PAD on completion accept.
  - PAD: append 0x80 at byte position byte_cnt mod 64, completing the partial word with zeros.
  - ZERO: emit all-zero words until word_index reaches 14. This may wrap into a new block when the 0x80 byte lands at byte position >= 56 (byte_cnt mod 64 >= 56).
  - LEN_HI: emit W14 = bit length [63:32].
  - LEN_LO: emit W15 = bit length [31:0] with block_last=1.
  - LEN_LO handshake -> DONE. DONE asserts msg_done for 1 cycle -> IDLE.
- Padding words are produced at up to one word per cycle, gated only by word_ready.
- block_last=1 only on the final W15. W15 of any earlier block has block_last=0.
- Empty message (completion with byte_cnt=0) is legal and produces a single block.
- byte_cnt wraps modulo 2^CNT_W. Messages of 2^CNT_W bytes or more are unsupported, and the length field is then undefined.

Test Plan:
- "CSE30342" (43 53 45 33 30 33 34 32), then input_complete with load_enable still high, word_ready=1 -> 16 words:
  - W0=43534533, W1=30333432, W2=80000000, W3..W14=0, W15=00000040.
  - block_last=1 on W15 only, msg_done 1 cycle later, and the last byte is not duplicated.
- Empty message: input_complete immediately after reset -> W0=80000000, W1..W15=0, block_last=1 on W15.
- 55 bytes of 0x61 -> one block: W13=61616180, W14=0, W15=000001B8.
- 56 bytes of 0x61 -> two blocks:
  - Block 0: W14=80000000, W15=0, block_last=0.
  - Block 1: W0..W13=0, W15=000001C0, block_last=1.
- 64 bytes, word_ready toggled 1/0 every cycle -> no word lost or duplicated, word_out stable while stalled, byte_ready drops when both registers are full. Block 1: W0=80000000, W15=00000200.
- Reset pulse after 6 bytes, then message "abc" -> W0=61626380, W15=00000018; no residue from the aborted message.
